// File: rtl/alu_op_sequencer.sv
// Control sequencer for a single-bus ALU datapath: walks A->Y, B, execute, Z writeback.
// Moore FSM; every strobe is decoded from the state register and the latched opcode.
module alu_op_sequencer #(
    parameter logic [4:0] IDLE_CTRL = 5'b00000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] opcode,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       Rsrc_a_out,
    output logic       Rsrc_b_out,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       Rdest_in,
    output logic       LOin,
    output logic       HIin,
    output logic [4:0] ALUControl
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADY = 3'd1,
        S_OPB   = 3'd2,
        S_EXEC  = 3'd3,
        S_WBLO  = 3'd4,
        S_WBHI  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] op_q;
    logic       unary_q, wide_q, illegal_q;

    logic       op_supported, op_unary, op_wide, accept;

    // Opcode classification of the live input, used only at acceptance
    always_comb begin
        op_supported = 1'b0;
        op_unary     = 1'b0;
        op_wide      = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR:
                op_supported = 1'b1;
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: begin
                op_supported = 1'b1;
                op_unary     = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                op_supported = 1'b1;
                op_wide      = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = (state == S_IDLE) && start && op_supported;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Operation context is frozen at acceptance so later opcode changes are invisible
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q      <= IDLE_CTRL;
            unary_q   <= 1'b0;
            wide_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state == S_IDLE) && start && !op_supported;
            if (accept) begin
                op_q    <= opcode;
                unary_q <= op_unary;
                wide_q  <= op_wide;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LOADY;
            S_LOADY: state_nxt = S_OPB;
            S_OPB:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WBLO;
            S_WBLO:  state_nxt = wide_q ? S_WBHI : S_DONE;
            S_WBHI:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = illegal_q;
        Rsrc_a_out = 1'b0;
        Rsrc_b_out = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        Rdest_in   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        ALUControl = IDLE_CTRL;
        case (state)
            S_LOADY: begin
                busy       = 1'b1;
                Rsrc_a_out = 1'b1;
                Yin        = 1'b1;
            end
            S_OPB: begin
                busy       = 1'b1;
                Rsrc_b_out = !unary_q;
            end
            // B stays on the bus from OPB so the ALU sees stable inputs when the op changes
            S_EXEC: begin
                busy       = 1'b1;
                Rsrc_b_out = !unary_q;
                Zin        = 1'b1;
                ALUControl = op_q;
            end
            S_WBLO: begin
                busy     = 1'b1;
                Zlowout  = 1'b1;
                Rdest_in = !wide_q;
                LOin     = wide_q;
            end
            S_WBHI: begin
                busy     = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
